// File: rtl/fsm_state_monitor.sv
// Passive monitor for the traffic FSM state bus: transition log FIFO, dwell timer, illegal/stuck watchdog.
// Optional saturating transition counter is built when STATE_MON_TRANS_CNT_EN is defined.

module fsm_state_monitor #(
  parameter int STATE_W   = 8,
  parameter int CNT_W     = 16,
  parameter int MAX_DWELL = 1000,
  parameter int LOG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STATE_W-1:0]   state,
  input  logic                 mant,
  input  logic                 log_rd,
  output logic                 log_valid,
  output logic [2*STATE_W-1:0] log_data,
  output logic                 log_overflow,
  output logic                 chg,
  output logic [CNT_W-1:0]     dwell,
  output logic                 illegal,
  output logic                 stuck,
  output logic [1:0]           mon_state,
  output logic [CNT_W-1:0]     trans_count
);

  localparam int               PTR_W       = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT    = (PTR_W+1)'(LOG_DEPTH);
  localparam logic [CNT_W-1:0] DWELL_LIMIT = CNT_W'(MAX_DWELL - 1);

  typedef enum logic [1:0] {
    MON_INIT  = 2'd0,
    MON_RUN   = 2'd1,
    MON_MAINT = 2'd2,
    MON_FAULT = 2'd3
  } mon_state_e;

  logic [STATE_W-1:0]   s_q, prev_q;
  logic                 m_q;
  mon_state_e           mon_q;
  logic [CNT_W-1:0]     dwell_q;
  logic                 chg_q, illegal_q, stuck_q;
  logic                 multi_hot, change;

  logic [2*STATE_W-1:0] mem [LOG_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic                 ovf_q, fifo_empty, fifo_full, pop, push_ok;

  // NOTE: the sample stage is deliberately not reset, so the bus value captured at
  // the reset edge is what INIT loads into prev_q and no false change follows.
  always_ff @(posedge clk) begin
    s_q <= state;
    m_q <= mant;
  end

  assign multi_hot = ($countones(s_q) > 1);
  assign change    = (mon_q != MON_INIT) && (s_q != prev_q);

  // NOTE: sequential state uses non-blocking assignments only; later assignments in
  // the same block (dwell clears below) deliberately override the default update.
  always_ff @(posedge clk) begin
    if (rst) begin
      mon_q     <= MON_INIT;
      prev_q    <= '0;
      dwell_q   <= '0;
      chg_q     <= 1'b0;
      illegal_q <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      chg_q <= change;
      if (change) begin
        prev_q  <= s_q;
        dwell_q <= '0;
      end else if (dwell_q != '1) begin
        dwell_q <= dwell_q + CNT_W'(1);
      end

      unique case (mon_q)
        MON_INIT: begin
          prev_q  <= s_q;
          dwell_q <= '0;
          if (multi_hot) begin
            illegal_q <= 1'b1;
            mon_q     <= MON_FAULT;
          end else begin
            mon_q <= m_q ? MON_MAINT : MON_RUN;
          end
        end
        MON_RUN: begin
          if (multi_hot) begin
            illegal_q <= 1'b1;
            mon_q     <= MON_FAULT;
          end else if (m_q) begin
            mon_q <= MON_MAINT;
          end else if (!change && dwell_q == DWELL_LIMIT) begin
            stuck_q <= 1'b1;
            mon_q   <= MON_FAULT;
          end
        end
        MON_MAINT: begin
          if (multi_hot) begin
            illegal_q <= 1'b1;
            mon_q     <= MON_FAULT;
          end else if (!m_q) begin
            mon_q   <= MON_RUN;
            dwell_q <= '0;
          end
        end
        MON_FAULT: ;  // left only through rst
        default: mon_q <= MON_FAULT;
      endcase
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pop        = log_rd && !fifo_empty;
  assign push_ok    = change && (!fifo_full || pop);

  // NOTE: log storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {prev_q, s_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: ;
      endcase
      if (change && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

`ifdef STATE_MON_TRANS_CNT_EN
  logic [CNT_W-1:0] trans_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trans_q <= '0;
    end else if (change && trans_q != '1) begin
      trans_q <= trans_q + CNT_W'(1);
    end
  end

  assign trans_count = trans_q;
`else
  assign trans_count = '0;
`endif

  assign log_valid    = !fifo_empty;
  assign log_data     = fifo_empty ? '0 : mem[rd_ptr_q];
  assign log_overflow = ovf_q;
  assign chg          = chg_q;
  assign dwell        = dwell_q;
  assign illegal      = illegal_q;
  assign stuck        = stuck_q;
  assign mon_state    = mon_q;

endmodule

// File: doc/fsm_state_monitor.md
Name: fsm_state_monitor

Overview:
- Passive reader of the traffic FSM's 8-bit `state` bus and `mant` input. Checks each state change as the FSM drives it.
- Logs every state transition into a small FIFO and measures dwell time in each state.
- Flags illegal encodings and stuck states through a watchdog.
- Sits beside `topLevel` in the integrated design and benches; its outputs feed debug LEDs or a host readout.

Parameters:
- STATE_W, 8, width of observed state bus
- CNT_W, 16, width of dwell counter
- MAX_DWELL, 1000, dwell cycles (while not in maintenance) after which `stuck` asserts; must be < 2^CNT_W
- LOG_DEPTH, 4, transition FIFO entries, power of two

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- state  in  STATE_W  FSM state bus being monitored; legal codes are 0 or one-hot
- mant  in  1  maintenance request, same signal driven into the FSM
- log_rd  in  1  pop request for transition log
- log_valid  out  1  log non-empty; log_data valid
- log_data  out  2*STATE_W  head entry {prev_state, new_state}
- log_overflow  out  1  sticky: a push was dropped while full
- chg  out  1  one-cycle pulse on a detected state change
- dwell  out  CNT_W  cycles spent in current state, saturating
- illegal  out  1  sticky: state had more than one bit set
- stuck  out  1  sticky: dwell reached MAX_DWELL outside maintenance
- mon_state  out  2  monitor FSM: 0 INIT, 1 RUN, 2 MAINT, 3 FAULT
- trans_count  out  CNT_W  total transitions seen (optional feature)

Behaviour:
- Reset (rst=1 at an edge):
  - All outputs go to 0; mon_state=INIT.
  - FIFO is emptied; prev_q=0.
  - Reset takes priority over every other event, including mid-pop.
- Sampling and change detection:
  - `state` and `mant` are registered once, giving s_q and m_q.
  - Change = s_q != prev_q, evaluated only outside INIT.
  - `chg` is a pulse one cycle after the registered sample; it is 2 cycles after the bus change.
  - On a change: push {prev_q, s_q}, set prev_q<=s_q, and clear dwell to 0. Otherwise dwell increments, saturating at all-ones.
- Monitor FSM:
  - INIT: on the first edge after reset, load prev_q<=s_q with no push and no chg, then go to RUN. If m_q=1, go to MAINT instead.
  - RUN -> MAINT when m_q=1. MAINT -> RUN when m_q=0.
  - In RUN, dwell == MAX_DWELL-1 with no change sets `stuck` and goes to FAULT.
  - In MAINT, dwell keeps counting but the watchdog is suspended. On return to RUN, dwell clears to 0.
  - Any s_q with popcount>1 sets `illegal` and goes to FAULT. This check applies in RUN and MAINT; an illegal value sampled in INIT also goes to FAULT.
  - FAULT is left only by rst. Logging, chg and dwell keep operating in FAULT.
- Log FIFO:
  - log_data always shows the head entry; log_valid = not empty.
  - A pop happens on log_rd & log_valid. log_rd while empty is ignored.
  - Push while full: entry dropped, log_overflow=1 (sticky).
  - Push and pop in the same cycle while full: both happen, no overflow.
  - Push and pop in the same cycle while empty: no pop; the pushed entry appears next cycle.
  - Pointers wrap modulo LOG_DEPTH; occupancy counter width is log2(LOG_DEPTH)+1.

Optional Feature:
- Macro: STATE_MON_TRANS_CNT_EN.
- Defined: trans_count increments on every detected change, saturating at 2^CNT_W-1, and clears on rst.
- Undefined: the counter is not built and trans_count is tied to 0. The port list is unchanged.

Test Plan:
- rst=1 for 1 cycle, then state=8'h01 held → mon_state INIT→RUN, chg never pulses, log_valid=0, dwell increments from 0.
- state steps 01→02→04→08, each held 10 cycles; no log_rd → 3 chg pulses, log holds {01,02},{02,04},{04,08}; log_rd pops them in that order. trans_count=3 with the macro, 0 without.
- state held at 8'h01 with MAX_DWELL=20 and mant=0 → stuck=1 and mon_state=FAULT exactly 20 cycles after the dwell clear. Repeat with mant=1 → no stuck, mon_state=MAINT; drop mant → RUN, dwell=0.
- state=8'h03 for 1 cycle → illegal=1, FAULT, sticky after state returns to 8'h01; rst clears it.
- LOG_DEPTH=4 with 5 changes and no reads → log_overflow=1 and the 5th entry is lost. Next, a push and a log_rd in the same cycle at full → count stays 4, no new overflow.
- Assert rst mid-sequence with the log holding 2 entries → next cycle log_valid=0, dwell=0, flags=0, mon_state=INIT.
